clk_gate_sched: RTL and testbench
=================================

// Module: clk_gate_sched
// PURPOSE
//   Sequences the enable (E) pins of N_DOM TLATNCAX2 integrated clock gates for the risc8 core.
//   Each domain is gated off after IDLE_THR consecutive idle cycles and re-enabled on request.
//   Wake-ups are serialised by a round-robin arbiter, so at most one domain restarts its clock
//   per window, which limits di/dt. Sits in the always-on clock/reset block next to the ICG cells.
// PARAMETERS
//   N_DOM     4   number of gated clock domains (>=2)
//   IDLE_W    8   idle counter / threshold width
//   WAKE_CYC  2   cycles from E rising to RDY rising (>=1)
// PORTS
//   CK        in   1       clock (ungated, always-on)
//   RN        in   1       reset, synchronous, active-low
//   REQ       in   N_DOM   per-domain activity request; held high until RDY[i]
//   BUSY      in   N_DOM   domain reports work in flight; blocks idle counting
//   IDLE_THR  in   IDLE_W  idle cycles before gating; 0 = auto-gating disabled
//   FORCE_ON  in   1       override: all clocks run
//   E         out  N_DOM   to ICG E pins; registered (flop outputs only)
//   RDY       out  N_DOM   domain clock running, request served; registered
//   WAKING    out  1       a wake window is in progress; registered
// BEHAVIOUR
//   Reset (RN=0 at CK rise): every domain goes to CG_ON; E=all 1, RDY=all 1, WAKING=0,
//     idle counters=0, RR pointer=0.
//   Per-domain FSM states: CG_ON, CG_OFF, CG_WAKE.
//   CG_ON:
//     - idle = !REQ[i] & !BUSY[i] & (IDLE_THR!=0) & !FORCE_ON.
//     - idle: cnt <= cnt+1 (saturating). Not idle: cnt <= 0.
//     - idle & (cnt+1 >= IDLE_THR): -> CG_OFF at that edge, with E[i]<=0, RDY[i]<=0, cnt<=0.
//       So E falls at the edge that completes IDLE_THR consecutive idle cycles.
//     - REQ or BUSY in the threshold cycle: stays CG_ON (activity wins).
//     - IDLE_THR lowered below cnt: gates at the next idle edge (>= compare).
//   CG_OFF:
//     - A domain with REQ[i]=1 is a wake candidate.
//     - The arbiter grants one candidate only when no domain is in CG_WAKE.
//       Winner = first candidate at or after the RR pointer.
//     - On grant: -> CG_WAKE, E[i]<=1, wake cnt<=WAKE_CYC-1, pointer <= winner+1 mod N_DOM.
//     - Losers stay CG_OFF and remain candidates.
//   CG_WAKE:
//     - wake cnt decrements each cycle; at 0 -> CG_ON, RDY[i]<=1.
//     - RDY rises exactly WAKE_CYC cycles after E, so E rises 1 cycle after REQ is sampled.
//     - REQ dropping during CG_WAKE does not abort; the domain reaches CG_ON and idle-counts.
//   WAKING = 1 while any domain is in CG_WAKE.
//   FORCE_ON=1: next edge all E<=1. CG_OFF/CG_WAKE domains -> CG_ON with RDY<=1, counters held 0,
//     arbiter idle. On deassert, counting restarts from 0.
//   E only changes at CK rise, so it is stable through the CK-low transparent phase of the ICG
//     latch and ECK cannot glitch.
//   RN=0 mid-wake or mid-count: reset values at that edge, with no partial state retained.
// STRUCTURE
//   Package clk_gate_pkg holds:
//     - typedef enum {CG_ON, CG_OFF, CG_WAKE} cg_state_t
//     - localparam CG_WAKE_W = $clog2(WAKE_CYC+1)
//   Sub-module cg_domain_fsm: one per domain. It owns the state, idle cnt, wake cnt and the
//     E/RDY flops. Inputs: req, busy, thr, force, grant. Output: cand (wake candidate).
//   Top level holds the RR arbiter (one-hot grant, pointer flop) and the WAKING flop,
//     and generates N_DOM cg_domain_fsm instances.
// TESTING
//   1 Reset, IDLE_THR=3, REQ=BUSY=0 -> E=1111 for 3 cycles after RN high, then E[0..3]=0 and RDY=0
//     at the 3rd edge.
//   2 All OFF, REQ=0001 at edge t -> E[0]=1 at t+1, WAKING=1 t+1..t+2, RDY[0]=1 at t+3 (WAKE_CYC=2).
//   3 All OFF, REQ=1111 at once -> wakes granted in order 0,1,2,3, one WAKE window each,
//     never two E rises within 2 cycles; then ptr=0 -> REQ=0101 repeated grants 0 then 2.
//   4 ON, IDLE_THR=4, BUSY pulses every 3rd cycle -> never gates. BUSY held 0 -> gates 4 edges
//     after the last pulse.
//   5 Domain 1 in CG_WAKE, FORCE_ON=1 -> next edge E=1111, RDY=1111, WAKING=0. Release -> regates
//     after IDLE_THR.
//   6 RN=0 during a wake window -> next edge E=1111, RDY=1111, WAKING=0. IDLE_THR=0 -> no gating
//     after 300 idle cycles.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-gate scheduler.
// Each gated domain moves between running, gated-off and a timed wake window.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_ON   = 2'd0,
    CG_OFF  = 2'd1,
    CG_WAKE = 2'd2
  } cg_state_t;

  localparam int CG_WAKE_CYC_DEF = 2;
  localparam int CG_WAKE_W       = $clog2(CG_WAKE_CYC_DEF + 1);

endpackage

// File: rtl/cg_domain_fsm.sv
// Per-domain gate controller: idle counting, gate-off, granted wake window.
// Drives the ICG enable and the ready flag directly from flops.
module cg_domain_fsm
  import clk_gate_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rn,
  input  logic              req,
  input  logic              busy,
  input  logic [IDLE_W-1:0] thr,
  input  logic              force_on,
  input  logic              grant,
  output logic              e,
  output logic              rdy,
  output logic              cand,
  output logic              in_wake,
  output logic              wake_done
);

  localparam int WAKE_W = $clog2(WAKE_CYC + 1);

  cg_state_t         state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              idle;
  logic [IDLE_W:0]   cnt_inc;

  assign idle      = !req && !busy && (thr != '0) && !force_on;
  assign cnt_inc   = {1'b0, idle_cnt} + (IDLE_W+1)'(1);
  assign in_wake   = (state == CG_WAKE);
  assign wake_done = in_wake && (wake_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rn) begin
      state    <= CG_ON;
      e        <= 1'b1;
      rdy      <= 1'b1;
      cand     <= 1'b0;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      cand <= 1'b0;
      unique case (state)
        CG_ON: begin
          if (idle) begin
            // Gate on the edge that completes the threshold run; >= also
            // covers a threshold lowered below the current count.
            if (cnt_inc >= {1'b0, thr}) begin
              state    <= CG_OFF;
              e        <= 1'b0;
              rdy      <= 1'b0;
              idle_cnt <= '0;
            end else if (!(&idle_cnt)) begin
              idle_cnt <= cnt_inc[IDLE_W-1:0];
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        CG_OFF: begin
          if (force_on) begin
            state <= CG_ON;
            e     <= 1'b1;
            rdy   <= 1'b1;
          end else if (grant) begin
            state    <= CG_WAKE;
            e        <= 1'b1;
            wake_cnt <= WAKE_W'(WAKE_CYC - 1);
          end else begin
            cand <= req;
          end
        end
        CG_WAKE: begin
          if (force_on || (wake_cnt == '0)) begin
            state    <= CG_ON;
            rdy      <= 1'b1;
            wake_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt - WAKE_W'(1);
          end
        end
        default: state <= CG_ON;
      endcase
    end
  end

endmodule

// File: rtl/clk_gate_sched.sv
// Clock-gate scheduler: one controller per domain plus a round-robin arbiter
// that lets only one domain restart its clock per wake window.
module clk_gate_sched
  import clk_gate_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              CK,
  input  logic              RN,
  input  logic [N_DOM-1:0]  REQ,
  input  logic [N_DOM-1:0]  BUSY,
  input  logic [IDLE_W-1:0] IDLE_THR,
  input  logic              FORCE_ON,
  output logic [N_DOM-1:0]  E,
  output logic [N_DOM-1:0]  RDY,
  output logic              WAKING
);

  localparam int PTR_W = $clog2(N_DOM);

  logic [N_DOM-1:0] cand;
  logic [N_DOM-1:0] grant;
  logic [N_DOM-1:0] in_wake;
  logic [N_DOM-1:0] wake_done;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  int               win;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    cg_domain_fsm #(
      .IDLE_W   (IDLE_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_dom (
      .clk       (CK),
      .rn        (RN),
      .req       (REQ[i]),
      .busy      (BUSY[i]),
      .thr       (IDLE_THR),
      .force_on  (FORCE_ON),
      .grant     (grant[i]),
      .e         (E[i]),
      .rdy       (RDY[i]),
      .cand      (cand[i]),
      .in_wake   (in_wake[i]),
      .wake_done (wake_done[i])
    );
  end

  // First candidate at or after the pointer wins; no grant while any window is open.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    win     = -1;
    if (!FORCE_ON && !(|in_wake)) begin
      for (int k = 0; k < N_DOM; k++) begin
        for (int j = 0; j < N_DOM; j++) begin
          if (win < 0 && cand[j] && (j == (int'(ptr) + k) % N_DOM)) win = j;
        end
      end
      for (int j = 0; j < N_DOM; j++) begin
        if (j == win) grant[j] = 1'b1;
      end
      if (win >= 0) ptr_nxt = PTR_W'((win + 1) % N_DOM);
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      ptr    <= '0;
      WAKING <= 1'b0;
    end else begin
      ptr    <= ptr_nxt;
      WAKING <= !FORCE_ON && ((|grant) || (|(in_wake & ~wake_done)));
    end
  end

endmodule

// File: tb/tb_clk_gate_sched.sv
// Scoreboard bench for clk_gate_sched: a timestamp-based reference model
// predicts E/RDY/WAKING per edge; a negedge monitor pops and compares.
module tb_clk_gate_sched;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int WC = 2;

  logic          CK = 1'b0;
  logic          RN;
  logic [N-1:0]  REQ, BUSY;
  logic [IW-1:0] IDLE_THR;
  logic          FORCE_ON;
  logic [N-1:0]  E, RDY;
  logic          WAKING;

  always #5 CK = ~CK;

  clk_gate_sched #(.N_DOM(N), .IDLE_W(IW), .WAKE_CYC(WC)) dut (
    .CK(CK), .RN(RN), .REQ(REQ), .BUSY(BUSY), .IDLE_THR(IDLE_THR),
    .FORCE_ON(FORCE_ON), .E(E), .RDY(RDY), .WAKING(WAKING)
  );

  typedef struct {
    logic [N-1:0] e;
    logic [N-1:0] rdy;
    logic         w;
    int           en;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: gated flag, edge at which RDY returns, idle run length,
  // request-seen flag and round-robin pointer.
  bit   m_off [N];
  int   m_wend[N];
  int   m_run [N];
  bit   m_seen[N];
  int   m_ptr;
  int   edge_no = 0;
  int   rise_q[$];
  int   rise_t[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic [N-1:0] req, input logic [N-1:0] busy,
                            input logic [IW-1:0] thr, input logic frc, output exp_t x);
    bit wake_prev;
    int w;
    wake_prev = 0;
    w = -1;
    for (int i = 0; i < N; i++) if (m_wend[i] > edge_no - 1) wake_prev = 1;
    if (!rn || frc) begin
      for (int i = 0; i < N; i++) begin
        m_off[i] = 0; m_wend[i] = 0; m_run[i] = 0; m_seen[i] = 0;
      end
      if (!rn) m_ptr = 0;
    end else begin
      if (!wake_prev)
        for (int k = 0; k < N; k++)
          if (w < 0 && m_off[(m_ptr + k) % N] && m_seen[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      for (int i = 0; i < N; i++) begin
        if (i == w) begin
          m_off[i] = 0; m_wend[i] = edge_no + WC; m_seen[i] = 0;
        end else if (m_off[i]) begin
          m_seen[i] = req[i];
        end else if (m_wend[i] > edge_no - 1) begin
          m_run[i] = 0;
        end else if (!req[i] && !busy[i] && thr != 0) begin
          m_run[i]++;
          if (m_run[i] >= int'(thr)) begin
            m_off[i] = 1; m_run[i] = 0; m_seen[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (w >= 0) m_ptr = (w + 1) % N;
    end
    x.w = 0;
    for (int i = 0; i < N; i++) begin
      x.e[i]   = !m_off[i];
      x.rdy[i] = !m_off[i] && (edge_no >= m_wend[i]);
      if (m_wend[i] > edge_no) x.w = 1;
    end
    x.en = edge_no;
  endtask

  task automatic step(input logic rn, input logic [N-1:0] req, input logic [N-1:0] busy,
                      input logic [IW-1:0] thr, input logic frc);
    exp_t x;
    RN = rn; REQ = req; BUSY = busy; IDLE_THR = thr; FORCE_ON = frc;
    edge_no++;
    model_edge(rn, req, busy, thr, frc, x);
    @(posedge CK);
    sbq.push_back(x);
    last_exp = x;
    #1;
  endtask

  task automatic idle_steps(input int n, input logic [IW-1:0] thr);
    for (int c = 0; c < n; c++) step(1'b1, '0, '0, thr, 1'b0);
  endtask

  // Hold REQ for the masked domains until each sees RDY; log E rise order/times.
  task automatic serve(input logic [N-1:0] mask, input logic [IW-1:0] thr);
    logic [N-1:0] done, prev_e;
    done = '0;
    rise_q.delete();
    rise_t.delete();
    for (int c = 0; c < 40 && done != mask; c++) begin
      prev_e = E;
      step(1'b1, mask & ~done, '0, thr, 1'b0);
      for (int i = 0; i < N; i++)
        if (E[i] && !prev_e[i]) begin rise_q.push_back(i); rise_t.push_back(c); end
      done |= RDY & mask;
    end
    chk("serve_all_ready", 64'(done), 64'(mask));
  endtask

  always @(negedge CK) begin
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk($sformatf("outputs@edge%0d", x.en), 64'({E, RDY, WAKING}), 64'({x.e, x.rdy, x.w}));
    end
  end

  initial begin
    logic [N-1:0] rq, bz;
    logic [IW-1:0] thr;
    logic frc, rn;
    int frc_left;

    // Reset then auto-gating after three idle edges
    step(1'b0, '0, '0, 8'd3, 1'b0);
    chk("reset_out", 64'({E, RDY, WAKING}), 64'({4'b1111, 4'b1111, 1'b0}));
    step(1'b1, '0, '0, 8'd3, 1'b0);
    step(1'b1, '0, '0, 8'd3, 1'b0);
    chk("idle_edge2_on", 64'(E), 64'(4'b1111));
    step(1'b1, '0, '0, 8'd3, 1'b0);
    chk("idle_edge3_off", 64'({E, RDY}), 64'({4'b0000, 4'b0000}));

    // Single wake: E one edge after REQ sampled, RDY WAKE_CYC later
    step(1'b1, 4'b0001, '0, 8'd3, 1'b0);
    chk("wake_t0", 64'({E, RDY, WAKING}), 64'({4'b0000, 4'b0000, 1'b0}));
    step(1'b1, 4'b0001, '0, 8'd3, 1'b0);
    chk("wake_t1", 64'({E, RDY, WAKING}), 64'({4'b0001, 4'b0000, 1'b1}));
    step(1'b1, 4'b0001, '0, 8'd3, 1'b0);
    chk("wake_t2", 64'({E, RDY, WAKING}), 64'({4'b0001, 4'b0000, 1'b1}));
    step(1'b1, 4'b0001, '0, 8'd3, 1'b0);
    chk("wake_t3", 64'({E, RDY, WAKING}), 64'({4'b0001, 4'b0001, 1'b0}));
    idle_steps(6, 8'd3);

    // Serialised wakes from a fresh pointer
    step(1'b0, '0, '0, 8'd3, 1'b0);
    idle_steps(3, 8'd3);
    serve(4'b1111, 8'd3);
    chk("rr_count", 64'(rise_q.size()), 64'(4));
    for (int k = 0; k < 4 && k < rise_q.size(); k++) begin
      chk($sformatf("rr_order%0d", k), 64'(rise_q[k]), 64'(k));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(rise_t[k] - rise_t[k-1] >= WC + 1), 64'(1));
    end
    for (int r = 0; r < 2; r++) begin
      idle_steps(8, 8'd3);
      serve(4'b0101, 8'd3);
      chk($sformatf("rr2_count%0d", r), 64'(rise_q.size()), 64'(2));
      if (rise_q.size() == 2) begin
        chk($sformatf("rr2_first%0d", r), 64'(rise_q[0]), 64'(0));
        chk($sformatf("rr2_second%0d", r), 64'(rise_q[1]), 64'(2));
      end
    end

    // BUSY pulses every third cycle keep all domains on
    step(1'b0, '0, '0, 8'd4, 1'b0);
    for (int c = 0; c < 30; c++) step(1'b1, '0, (c % 3 == 2) ? 4'b1111 : 4'b0000, 8'd4, 1'b0);
    chk("busy_never_gates", 64'(E), 64'(4'b1111));
    idle_steps(3, 8'd4);
    chk("busy_released_3", 64'(E), 64'(4'b1111));
    idle_steps(1, 8'd4);
    chk("busy_released_4", 64'(E), 64'(4'b0000));

    // FORCE_ON during a wake window
    step(1'b1, 4'b0010, '0, 8'd4, 1'b0);
    step(1'b1, 4'b0010, '0, 8'd4, 1'b0);
    chk("force_pre_wake", 64'({E, WAKING}), 64'({4'b0010, 1'b1}));
    step(1'b1, 4'b0010, '0, 8'd4, 1'b1);
    chk("force_on_out", 64'({E, RDY, WAKING}), 64'({4'b1111, 4'b1111, 1'b0}));
    idle_steps(3, 8'd4);
    chk("force_release_3", 64'(E), 64'(4'b1111));
    idle_steps(1, 8'd4);
    chk("force_release_4", 64'(E), 64'(4'b0000));

    // Reset during a wake window, then gating disabled
    step(1'b1, 4'b0100, '0, 8'd4, 1'b0);
    step(1'b1, 4'b0100, '0, 8'd4, 1'b0);
    chk("rst_pre_wake", 64'({E, WAKING}), 64'({4'b0100, 1'b1}));
    step(1'b0, 4'b0100, '0, 8'd4, 1'b0);
    chk("rst_mid_wake", 64'({E, RDY, WAKING}), 64'({4'b1111, 4'b1111, 1'b0}));
    idle_steps(300, 8'd0);
    chk("thr0_no_gating", 64'({E, RDY}), 64'({4'b1111, 4'b1111}));

    // Randomised traffic, REQ held until RDY (occasionally dropped mid-wake)
    rq = '0; thr = 8'd3; frc_left = 0;
    for (int c = 0; c < 900; c++) begin
      if (c % 64 == 0) begin
        thr = IW'($urandom % 8);
      end
      for (int i = 0; i < N; i++) begin
        if (rq[i]) begin
          if (last_exp.rdy[i]) rq[i] = ($urandom % 2) == 0;
          else rq[i] = ($urandom % 10) != 0;
        end else begin
          rq[i] = last_exp.e[i] ? (($urandom % 12) == 0) : (($urandom % 6) == 0);
        end
        bz[i] = ($urandom % 8) == 0;
      end
      if (frc_left > 0) begin
        frc = 1'b1; frc_left--;
      end else begin
        frc = 1'b0;
        if ($urandom % 60 == 0) frc_left = $urandom_range(1, 3);
      end
      rn = ($urandom % 150) != 0;
      step(rn, rq, bz, thr, frc);
    end

    idle_steps(2, 8'd3);
    @(negedge CK);
    @(negedge CK);
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
